fma16_sequencer: RTL and testbench

//  Request/response front end for the combinational fma16 datapath.
//  - Accepts one encoded FP16 op per handshake and decodes it to fma16 controls.
//  - Holds operands stable for fma16, captures result/flags, returns them with a tag.
//  - Keeps sticky IEEE flags and a completed-op counter for the core.

---
 rtl/fma16_seq_pkg.sv | 40 ++++
 rtl/fma16_op_decode.sv | 32 +++
 rtl/fma16_sequencer.sv | 145 ++++++++++++++
 tb/tb_fma16_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_seq_pkg.sv
// Shared types and constants for the fma16 request/response sequencer.
package fma16_seq_pkg;

    // Encoded FP16 operation carried on req_op.
    typedef enum logic [2:0] {
        FADD       = 3'd0,
        FSUB       = 3'd1,
        FMUL       = 3'd2,
        FMADD      = 3'd3,
        FMSUB      = 3'd4,
        FNMADD     = 3'd5,
        FNMSUB     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_t;

    // Sequencer states: wait for a request, let fma16 settle, hold the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bit positions inside the 4-bit IEEE flag vector {NV,OF,UF,NX}.
    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Canonical quiet NaN returned for an illegal op.
    localparam logic [15:0] QNAN16 = 16'h7E00;

    // Flag vector reported for an illegal op: invalid only.
    function automatic logic [3:0] illegal_flags();
        logic [3:0] f;
        f         = '0;
        f[FLG_NV] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/fma16_op_decode.sv
// Combinational decode of an op code into the fma16 control bits.
module fma16_op_decode
    import fma16_seq_pkg::*;
(
    input  op_t  op,
    output logic mul,
    output logic add,
    output logic negr,
    output logic negz,
    output logic illegal
);

    // Map each op to {mul,add,negr,negz}; the illegal op drives all controls low.
    always_comb begin
        mul     = 1'b0;
        add     = 1'b0;
        negr    = 1'b0;
        negz    = 1'b0;
        illegal = 1'b0;
        case (op)
            FADD:   begin add = 1'b1; end
            FSUB:   begin add = 1'b1; negz = 1'b1; end
            FMUL:   begin mul = 1'b1; end
            FMADD:  begin mul = 1'b1; add = 1'b1; end
            FMSUB:  begin mul = 1'b1; add = 1'b1; negz = 1'b1; end
            FNMADD: begin mul = 1'b1; add = 1'b1; negr = 1'b1; end
            FNMSUB: begin mul = 1'b1; add = 1'b1; negr = 1'b1; negz = 1'b1; end
            default: begin illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/fma16_sequencer.sv
// Request/response front end for the combinational fma16 datapath.
// Registers one op at a time, holds it on the fma16 inputs for EXEC_CYCLES,
// captures the result with its tag, and keeps sticky flags and an op counter.
module fma16_sequencer
    import fma16_seq_pkg::*;
#(
    parameter int TAGW        = 4,
    parameter int EXEC_CYCLES = 1,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [15:0]     req_x,
    input  logic [15:0]     req_y,
    input  logic [15:0]     req_z,
    input  logic [1:0]      req_rm,
    input  logic [TAGW-1:0] req_tag,

    output logic [15:0]     fma_x,
    output logic [15:0]     fma_y,
    output logic [15:0]     fma_z,
    output logic            fma_mul,
    output logic            fma_add,
    output logic            fma_negr,
    output logic            fma_negz,
    output logic [1:0]      fma_roundmode,
    input  logic [15:0]     fma_result,
    input  logic [3:0]      fma_flags,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_result,
    output logic [3:0]      rsp_flags,
    output logic [TAGW-1:0] rsp_tag,

    input  logic            fflags_clr,
    output logic [3:0]      fflags,
    output logic [CNTW-1:0] op_count
);

    // Execute-phase counter only needs to reach EXEC_CYCLES-1.
    localparam int            CW       = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

    state_t          state;
    logic [CW-1:0]   exec_cnt;
    logic            ill_q;
    logic [TAGW-1:0] tag_q;

    logic            dec_mul;
    logic            dec_add;
    logic            dec_negr;
    logic            dec_negz;
    logic            dec_illegal;
    logic            rsp_fire;

    fma16_op_decode u_decode (
        .op      (op_t'(req_op)),
        .mul     (dec_mul),
        .add     (dec_add),
        .negr    (dec_negr),
        .negz    (dec_negz),
        .illegal (dec_illegal)
    );

    assign req_ready = (state == ST_IDLE);
    assign rsp_fire  = rsp_valid & rsp_ready;

    // Sequencer FSM plus the operand, response, sticky-flag and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            exec_cnt      <= '0;
            ill_q         <= 1'b0;
            tag_q         <= '0;
            fma_x         <= '0;
            fma_y         <= '0;
            fma_z         <= '0;
            fma_mul       <= 1'b0;
            fma_add       <= 1'b0;
            fma_negr      <= 1'b0;
            fma_negz      <= 1'b0;
            fma_roundmode <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_flags     <= '0;
            rsp_tag       <= '0;
            fflags        <= '0;
            op_count      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Operands and controls stay on fma16 until the next accept.
                        fma_x         <= req_x;
                        fma_y         <= req_y;
                        fma_z         <= req_z;
                        fma_roundmode <= req_rm;
                        fma_mul       <= dec_mul;
                        fma_add       <= dec_add;
                        fma_negr      <= dec_negr;
                        fma_negz      <= dec_negz;
                        ill_q         <= dec_illegal;
                        tag_q         <= req_tag;
                        exec_cnt      <= '0;
                        state         <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    exec_cnt <= exec_cnt + 1'b1;
                    if (exec_cnt == CNT_LAST) begin
                        // An illegal op never looks at fma16; it reports a quiet NaN.
                        rsp_result <= ill_q ? QNAN16 : fma_result;
                        rsp_flags  <= ill_q ? illegal_flags() : fma_flags;
                        rsp_tag    <= tag_q;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase

            // A clear coinciding with a response keeps that response's flags.
            fflags <= (fflags_clr ? 4'b0000 : fflags) | (rsp_fire ? rsp_flags : 4'b0000);

            if (rsp_fire) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fma16_sequencer.sv
// Scoreboard bench for fma16_sequencer paired with a table-driven fma16 stand-in.
module tb_fma16_sequencer;
    import fma16_seq_pkg::*;

    localparam int TAGW = 4;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [15:0]     req_x, req_y, req_z;
    logic [1:0]      req_rm;
    logic [TAGW-1:0] req_tag;
    logic [15:0]     fma_x, fma_y, fma_z;
    logic            fma_mul, fma_add, fma_negr, fma_negz;
    logic [1:0]      fma_roundmode;
    logic [15:0]     fma_result;
    logic [3:0]      fma_flags;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [15:0]     rsp_result;
    logic [3:0]      rsp_flags;
    logic [TAGW-1:0] rsp_tag;
    logic            fflags_clr;
    logic [3:0]      fflags;
    logic [CNTW-1:0] op_count;
    logic [3:0]      fctrl;

    fma16_sequencer #(.TAGW(TAGW), .EXEC_CYCLES(1), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm), .req_tag(req_tag),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
        .fma_roundmode(fma_roundmode), .fma_result(fma_result), .fma_flags(fma_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .fflags_clr(fflags_clr), .fflags(fflags), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign fctrl = {fma_mul, fma_add, fma_negr, fma_negz};

    // Reference fma16 for the hand-computed vectors; anything else yields a poison value.
    function automatic logic [19:0] ref_fma(input logic [3:0] c, input logic [15:0] x,
                                            input logic [15:0] y, input logic [15:0] z);
        case ({c, x, y, z})
            {4'b0100, 16'h3C00, 16'h0000, 16'h3C00}: return {16'h4000, 4'b0000}; // 1+1
            {4'b0101, 16'h4000, 16'h0000, 16'h3C00}: return {16'h3C00, 4'b0000}; // 2-1
            {4'b1000, 16'h7BFF, 16'h4000, 16'h0000}: return {16'h7C00, 4'b0101}; // 65504*2 ovf
            {4'b1100, 16'h3C00, 16'h4000, 16'h3C00}: return {16'h4200, 4'b0000}; // 1*2+1
            {4'b1101, 16'h4000, 16'h4000, 16'h3C00}: return {16'h4200, 4'b0000}; // 2*2-1
            {4'b1110, 16'h4000, 16'h4000, 16'h3C00}: return {16'hC500, 4'b0000}; // -(2*2+1)
            {4'b1111, 16'h4000, 16'h4000, 16'h3C00}: return {16'hC200, 4'b0000}; // -(2*2-1)
            default:                                 return {16'hBAD0, 4'b0110};
        endcase
    endfunction

    always_comb begin
        {fma_result, fma_flags} = ref_fma(fctrl, fma_x, fma_y, fma_z);
    end

    // Directed vectors indexed by op code 0..6.
    logic [15:0] vx   [7] = '{16'h3C00, 16'h4000, 16'h7BFF, 16'h3C00, 16'h4000, 16'h4000, 16'h4000};
    logic [15:0] vy   [7] = '{16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    logic [15:0] vz   [7] = '{16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    logic [3:0]  vctl [7] = '{4'b0100, 4'b0101, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    logic [15:0] vres [7] = '{16'h4000, 16'h3C00, 16'h7C00, 16'h4200, 16'h4200, 16'hC500, 16'hC200};
    logic [3:0]  vflg [7] = '{4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    typedef struct {
        logic [15:0]     res;
        logic [3:0]      flg;
        logic [TAGW-1:0] tag;
        logic [3:0]      ctrl;
        logic [15:0]     x, y, z;
        logic [1:0]      rm;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   accept_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every response handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got result %0h tag %0h expected no response",
                         rsp_result, rsp_tag);
            end else begin
                e = sbq.pop_front();
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_flags",  rsp_flags,  e.flg);
                chk("rsp_tag",    rsp_tag,    e.tag);
                chk("fma_hold",   {fctrl, fma_x, fma_y, fma_z, fma_roundmode},
                                  {e.ctrl, e.x, e.y, e.z, e.rm});
            end
        end
    end

    // Issue one request; caller sits 1 time unit after a rising edge and returns in EXEC.
    task automatic send(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [1:0] rm, input logic [TAGW-1:0] tag,
                        input logic [15:0] eres, input logic [3:0] eflg, input logic [3:0] ectl,
                        input bit expect_rsp);
        exp_t e;
        int   w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op = op; req_x = x; req_y = y; req_z = z; req_rm = rm; req_tag = tag;
        if (expect_rsp) begin
            e.res = eres; e.flg = eflg; e.tag = tag; e.ctrl = ectl;
            e.x = x; e.y = y; e.z = z; e.rm = rm;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        req_valid = 1'b0;
        chk("exec_fma", {fctrl, fma_x, fma_y, fma_z, fma_roundmode}, {ectl, x, y, z, rm});
    endtask

    task automatic send_vec(input int v, input logic [1:0] rm, input logic [TAGW-1:0] tag);
        send(v[2:0], vx[v], vy[v], vz[v], rm, tag, vres[v], vflg[v], vctl[v], 1'b1);
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    task automatic wait_rsp_valid();
        int w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("rsp_valid_wait", rsp_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CNTW-1:0] exp_cnt;
        int              prev_acc;
        int              v;
        logic [1:0]      rm;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_z = '0;
        req_rm = '0; req_tag = '0; rsp_ready = 1'b1; fflags_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_regs",  {rsp_result, rsp_flags, rsp_tag}, '0);
        chk("rst_fflags",    fflags, 4'b0000);
        chk("rst_op_count",  op_count, 0);
        chk("rst_fma",       {fma_x, fma_y, fma_z, fctrl, fma_roundmode}, '0);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_cnt = '0;

        // 1: FMADD 1*2+1 with latency check
        send(FMADD, 16'h3C00, 16'h4000, 16'h3C00, 2'b00, 4'd5, 16'h4200, 4'b0000, 4'b1100, 1'b1);
        chk("lat_exec_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_resp_valid", rsp_valid, 1'b1);
        chk("lat_req_ready",  req_ready, 1'b0);
        @(posedge clk); #1;
        exp_cnt++;
        chk("t1_op_count", op_count, exp_cnt);
        chk("t1_req_ready", req_ready, 1'b1);

        // 2: FSUB then FMUL overflow
        send_vec(1, 2'b00, 4'd6);
        drain();
        send_vec(2, 2'b00, 4'd7);
        drain();
        exp_cnt += 2;
        chk("t2_fflags", fflags, 4'b0101);
        chk("t2_op_count", op_count, exp_cnt);

        // 3: backpressure; a request held during the stall must be ignored
        rsp_ready = 1'b0;
        send_vec(0, 2'b01, 4'd9);
        wait_rsp_valid();
        req_valid = 1'b1; req_op = FMUL; req_x = 16'h7BFF; req_y = 16'h4000; req_z = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_rsp_hold",  {rsp_result, rsp_flags, rsp_tag}, {16'h4000, 4'b0000, 4'd9});
            chk("bp_op_count",  op_count, exp_cnt);
        end
        req_valid = 1'b0;
        chk("bp_fma_x_hold", fma_x, 16'h3C00);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        chk("bp_release_cnt", op_count, exp_cnt);
        chk("bp_release_vld", rsp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_extra", op_count, exp_cnt);

        // 4: illegal op with a same-cycle sticky clear
        rsp_ready = 1'b0;
        send(OP_ILLEGAL, 16'h3C00, 16'h4000, 16'h3C00, 2'b00, 4'hA, 16'h7E00, 4'b1000, 4'b0000, 1'b1);
        wait_rsp_valid();
        chk("ill_fflags_before", fflags, 4'b0101);
        rsp_ready = 1'b1; fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        exp_cnt++;
        chk("ill_fflags_clr_fire", fflags, 4'b1000);
        chk("ill_op_count", op_count, exp_cnt);
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        chk("clr_only", fflags, 4'b0000);

        // 5: reset during EXEC, then during RESP
        send_vec(2, 2'b00, 4'd3);
        drain();
        exp_cnt++;
        chk("pre_rst_fflags", fflags, 4'b0101);
        send(FADD, 16'h3C00, 16'h0000, 16'h3C00, 2'b00, 4'd1, 16'h0, 4'h0, 4'b0100, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_exec_valid", rsp_valid, 1'b0);
        chk("rst_exec_ready", req_ready, 1'b1);
        chk("rst_exec_ff_cnt", {fflags, op_count}, '0);
        rsp_ready = 1'b0;
        send(FMUL, 16'h7BFF, 16'h4000, 16'h0000, 2'b00, 4'd2, 16'h0, 4'h0, 4'b1000, 1'b0);
        wait_rsp_valid();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; rsp_ready = 1'b1;
        chk("rst_resp_valid", rsp_valid, 1'b0);
        chk("rst_resp_ready", req_ready, 1'b1);
        chk("rst_resp_ff_cnt", {fflags, op_count}, '0);
        chk("rst_resp_fma", {fma_x, fctrl}, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_rsp_cnt", op_count, 0);

        // 6: 17 back-to-back ops, counter wraps to 1
        exp_cnt = '0;
        prev_acc = 0;
        for (int i = 0; i < 17; i++) begin
            v  = i % 7;
            rm = (v == 2) ? 2'b00 : 2'(i % 4);
            send_vec(v, rm, 4'(i));
            if (i > 0) chk("b2b_spacing", accept_cyc - prev_acc, 3);
            prev_acc = accept_cyc;
        end
        drain();
        chk("b2b_op_count", op_count, 1);
        chk("b2b_fflags", fflags, 4'b0101);

        repeat (3) @(posedge clk);
        chk("final_queue", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
